// File: rtl/aes_key_schedule_iter.sv
// Iterative AES-128 key expansion: one round key per clock into a packed
// 11x128 key bus consumed by the round-iterative cipher/decipher cores.

module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y_o = SBOX[a_i];

endmodule

module aes_key_schedule_iter #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [127:0]          key_in,
    output logic [(Nr+1)*128-1:0] all_keys,
    output logic                  keys_valid,
    output logic                  busy,
    output logic                  done
);

    if (Nk != 4 || Nr != 10) begin : g_bad_param
        $error("aes_key_schedule_iter supports only Nk=4, Nr=10");
    end

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    localparam int KW = (Nr + 1) * 128;

    state_t          state_q, state_d;
    logic [3:0]      rnd_q, rnd_d;
    logic [7:0]      rcon_q, rcon_d;
    logic [KW-1:0]   keys_q, keys_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [127:0]    prev;
    logic [31:0]     rot;
    logic [31:0]     sub;
    logic [31:0]     t;
    logic [31:0]     n0, n1, n2, n3;
    logic [7:0]      rcon_nxt;

    // Select the previously written slot (rnd-1) as the expansion source.
    always_comb begin
        prev = '0;
        for (int i = 0; i < Nr; i++) begin
            if (rnd_q == 4'(i + 1)) begin
                prev = keys_q[128*i +: 128];
            end
        end
    end

    assign rot = {prev[23:0], prev[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .a_i (rot[8*g +: 8]),
            .y_o (sub[8*g +: 8])
        );
    end

    assign t  = sub ^ {rcon_q, 24'h0};
    assign n0 = prev[127:96] ^ t;
    assign n1 = prev[95:64]  ^ n0;
    assign n2 = prev[63:32]  ^ n1;
    assign n3 = prev[31:0]   ^ n2;

    assign rcon_nxt = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        rcon_d  = rcon_q;
        keys_d  = keys_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    keys_d[127:0] = key_in;
                    rnd_d         = 4'd1;
                    rcon_d        = 8'h01;
                    busy_d        = 1'b1;
                    valid_d       = 1'b0;
                    state_d       = EXPAND;
                end
            end
            EXPAND: begin
                for (int i = 1; i <= Nr; i++) begin
                    if (rnd_q == 4'(i)) begin
                        keys_d[128*i +: 128] = {n0, n1, n2, n3};
                    end
                end
                rcon_d = rcon_nxt;
                // Counter parks at Nr on the final round; no wrap path.
                if (rnd_q == 4'(Nr)) begin
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rnd_q   <= 4'd0;
            rcon_q  <= 8'h01;
            keys_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            rcon_q  <= rcon_d;
            keys_q  <= keys_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign all_keys   = keys_q;
    assign keys_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_aes_key_schedule_iter.sv
// Scoreboard bench for aes_key_schedule_iter using FIPS-197 key vectors.

module tb_aes_key_schedule_iter;

    logic            clk;
    logic            reset;
    logic            start;
    logic [127:0]    key_in;
    logic [1407:0]   all_keys;
    logic            keys_valid;
    logic            busy;
    logic            done;

    aes_key_schedule_iter dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key_in     (key_in),
        .all_keys   (all_keys),
        .keys_valid (keys_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [127:0] KA [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] KB0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KB10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef struct {
        logic [1407:0] keys;
        bit            mid;
        int            done_cyc;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] slot(input int i);
        return all_keys[128*i +: 128];
    endfunction

    function automatic logic [1407:0] sched_a();
        logic [1407:0] v;
        for (int i = 0; i < 11; i++) v[128*i +: 128] = KA[i];
        return v;
    endfunction

    function automatic logic [1407:0] sched_b();
        logic [1407:0] v;
        v = '0;
        v[127:0] = KB0;
        v[1407:1280] = KB10;
        return v;
    endfunction

    task automatic push(input logic [1407:0] keys, input bit mid);
        exp_t e;
        e.keys = keys;
        e.mid = mid;
        e.done_cyc = cyc + 10;
        q.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 128'(cyc), 128'(-1));
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", 128'(cyc), 128'(e.done_cyc));
                    chk("done_slot0", slot(0), e.keys[127:0]);
                    chk("done_slot10", slot(10), e.keys[1407:1280]);
                    chk("done_valid", 128'(keys_valid), 128'(1));
                    chk("done_busy", 128'(busy), 128'(0));
                    if (e.mid) begin
                        for (int i = 1; i < 10; i++)
                            chk($sformatf("done_slot%0d", i), slot(i),
                                e.keys[128*i +: 128]);
                    end
                end
            end
        end
    endtask

    // Drives a start pulse; returns at the negedge right after E0.
    task automatic pulse_start(input logic [127:0] key);
        @(negedge clk);
        start = 1'b1;
        key_in = key;
        @(negedge clk);
        start = 1'b0;
        key_in = ~key;
    endtask

    task automatic watch(input int ign_k, input bit chk1,
                         input logic [127:0] s1, output int nb,
                         output int nd, output int fv);
        nb = 0;
        nd = 0;
        fv = -1;
        for (int k = 0; k < 14; k++) begin
            if (busy) nb++;
            if (done) nd++;
            if (keys_valid && fv < 0) fv = k;
            if (k < 10)
                chk($sformatf("rcon_r%0d", k + 1),
                    128'(dut.rcon_q), 128'(RCON[k]));
            if (k == 1 && chk1) chk("slot1_after_E1", slot(1), s1);
            if (k == ign_k - 1) begin
                start = 1'b1;
                key_in = KB0;
            end
            if (k == ign_k) start = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic chk_run(input string tag, input int nb, input int nd,
                           input int fv);
        chk({tag, "_busy_cycles"}, 128'(nb), 128'(10));
        chk({tag, "_done_cycles"}, 128'(nd), 128'(1));
        chk({tag, "_valid_return"}, 128'(fv), 128'(10));
        chk({tag, "_valid_held"}, 128'(keys_valid), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        int nb, nd, fv;
        reset = 1'b1;
        start = 1'b0;
        key_in = '0;
        fork
            monitor();
        join_none
        repeat (2) @(negedge clk);
        chk("rst_keys_lo", all_keys[127:0], 128'd0);
        chk("rst_keys_hi", all_keys[1407:1280], 128'd0);
        chk("rst_valid", 128'(keys_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_rcon", 128'(dut.rcon_q), 128'(8'h01));
        reset = 1'b0;

        pulse_start(KA[0]);
        push(sched_a(), 1'b1);
        chk("a_slot0", slot(0), KA[0]);
        chk("a_busy_E0", 128'(busy), 128'(1));
        chk("a_valid_E0", 128'(keys_valid), 128'(0));
        watch(-5, 1'b1, KA[1], nb, nd, fv);
        chk_run("a", nb, nd, fv);
        chk("a_hold_slot5", slot(5), KA[5]);

        pulse_start(KB0);
        push(sched_b(), 1'b0);
        chk("b_valid_drop", 128'(keys_valid), 128'(0));
        chk("b_slot0", slot(0), KB0);
        chk("b_slot1_stale", slot(1), KA[1]);
        watch(-5, 1'b0, '0, nb, nd, fv);
        chk_run("b", nb, nd, fv);

        pulse_start(KA[0]);
        push(sched_a(), 1'b1);
        watch(4, 1'b1, KA[1], nb, nd, fv);
        chk_run("ign", nb, nd, fv);

        pulse_start(KA[0]);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        key_in = KB0;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("abort_keys_lo", all_keys[127:0], 128'd0);
        chk("abort_keys_s4", slot(4), 128'd0);
        chk("abort_valid", 128'(keys_valid), 128'(0));
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_rnd", 128'(dut.rnd_q), 128'(0));
        repeat (3) @(negedge clk);
        chk("abort_idle_busy", 128'(busy), 128'(0));

        pulse_start(KA[0]);
        push(sched_a(), 1'b1);
        watch(-5, 1'b1, KA[1], nb, nd, fv);
        chk_run("fresh", nb, nd, fv);

        repeat (3) @(negedge clk);
        chk("queue_drained", 128'(q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aes_key_schedule_iter.md
Name: aes_key_schedule_iter

Overview:
Sequential AES-128 key expansion engine that sits directly upstream of the round-iterative cipher/decipher cores. It accepts a 128-bit cipher key on a start pulse and computes one round key per clock. It fills a packed 11x128-bit key bus that the decrypt core consumes unchanged. This replaces the purely combinational expansion, cutting S-box count from 40 to 4.

Parameters:
Nk, 4, key length in 32-bit words; only 4 is supported, other values are illegal.
Nr, 10, number of rounds; only 10 is supported, other values are illegal.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle request to expand key_in; sampled only in IDLE or DONE
key_in  input  128  cipher key, w0 in bits [127:96]; sampled on the start edge only
all_keys  output  (Nr+1)*128  packed round keys; round key i occupies [128*i+127 : 128*i]; round 0 in LSBs, round 10 in MSBs
keys_valid  output  1  high while all_keys holds a complete schedule
busy  output  1  high while expansion is in progress
done  output  1  one-cycle pulse when the schedule completes

Behaviour:
- Reset (synchronous, active-high): all_keys=0, keys_valid=0, busy=0, done=0, rnd=0, rcon=8'h01, state=IDLE. Reset wins over start on the same edge. Reset mid-expansion aborts the expansion and clears every output.
- FSM states: IDLE, EXPAND, DONE.
- IDLE:
  - start=1 at edge E0: slot 0 <= key_in; rnd <= 1; rcon <= 8'h01; busy <= 1; keys_valid <= 0; go to EXPAND.
- EXPAND, one round key per edge:
  - prev = slot rnd-1, words p0..p3, p0 in MSBs.
  - t = SubWord(RotWord(p3)) ^ {rcon, 24'h0}.
  - n0 = p0^t; n1 = p1^n0; n2 = p2^n1; n3 = p3^n2.
  - slot rnd <= {n0,n1,n2,n3}; rnd <= rnd+1; rcon <= xtime(rcon).
  - xtime = (rcon<<1) ^ (rcon[7] ? 8'h1b : 0).
  - Rcon sequence over rnd 1..10: 01,02,04,08,10,20,40,80,1b,36.
  - On rnd==Nr: write slot 10; busy <= 0; keys_valid <= 1; done <= 1; go to DONE.
- Latency:
  - Slot i is written at edge E0+i.
  - keys_valid, done and busy=0 are all visible after edge E10 (10 cycles after start).
  - done is high for exactly one cycle.
- start while in EXPAND is ignored; no queueing and no restart.
- DONE: all_keys is held stable; keys_valid stays 1.
  - start=1 in DONE restarts exactly as from IDLE: keys_valid drops at E0 and slot 0 is overwritten.
  - Slots 1..10 keep their stale values until rewritten.
- key_in changes outside the start edge have no effect.
- SubWord uses 4 instances of the team's forward S-box. Bytes are processed MSB-first. RotWord maps {a,b,c,d} to {b,c,d,a}.
- The round counter is 4 bits wide and never exceeds Nr; there is no wrap-around path.
- Consumer contract: the decrypt core must hold its enable low until keys_valid=1.

Test Plan:
- Key 2b7e151628aed2a6abf7158809cf4f3c, start pulse:
  - slot 1 = a0fafe1788542cb123a339392a6c7605 after E1;
  - slot 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 after E10;
  - done pulses exactly one cycle; busy is high for exactly 10 cycles.
- Key 000102030405060708090a0b0c0d0e0f:
  - slot 10 = 13111d7fe3944a17f307a78b4d2b30c5 and slot 0 = key.
  - Chain into the decrypt core with ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a; plaintext must be 00112233445566778899aabbccddeeff.
- start pulsed again at E4 during EXPAND:
  - ignored; done still occurs only after E10; all_keys matches the single-expansion golden values.
- reset asserted at E5 together with start:
  - next cycle all_keys=0, keys_valid=0, busy=0, state IDLE.
  - A fresh start afterwards gives the correct schedule.
- Back-to-back keys: in DONE, start with key 2b7e..., then with key 0001...:
  - keys_valid drops at the restart edge and returns 10 cycles later;
  - final slots match the second key's schedule.
- Check Rcon: dump rcon per round and compare against 01,02,04,08,10,20,40,80,1b,36.
